div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider serving the M-extension dispatcher in the execute stage.
- Consumes the 33-bit sign/zero-extended operands and level start from the dispatcher.
- Returns a 33-bit quotient and remainder, plus a valid pulse and a busy/stall indication for the pipeline.
- One shared datapath handles DIV, DIVU, REM and REMU: signed/unsigned is already encoded in operand bit 32.

Parameters:
- WIDTH, 33, operand/result width in bits (DATA_WIDTH+1); also the iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- div_start  input  1  level request; held high by the dispatcher while a divide op sits in EX.
- div_flush  input  1  pipeline kill; abandons any operation in progress.
- div_s1  input  WIDTH  dividend, two's complement.
- div_s2  input  WIDTH  divisor, two's complement.
- div_quotient  output  WIDTH  registered quotient.
- div_remainder  output  WIDTH  registered remainder.
- div_valid  output  1  one-cycle pulse; results valid.
- div_busy  output  1  stall request to the pipeline.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - CALC: WIDTH iterations in progress.
  - DONE: results presented, valid high for one cycle.
- Reset (rst=1 at a clk edge):
  - state=IDLE, counter=0.
  - div_quotient=0, div_remainder=0, div_valid=0.
  - div_busy is forced 0 while rst is high.
- Launch, IDLE with div_start=1 and div_flush=0, at the clock edge:
  - Latch magnitudes |s1| and |s2|, sign_q = s1[32]^s2[32], sign_r = s1[32].
  - Clear the partial remainder; counter=0; go to CALC.
- Divide-by-zero (div_s2==0 at launch):
  - Go straight IDLE->DONE.
  - Quotient = all ones (33'h1_FFFF_FFFF), remainder = div_s1 unchanged.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1; trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quo[0]=1.
  - After WIDTH iterations (counter==WIDTH-1), go to DONE.
- CALC->DONE edge: load the output registers with sign correction.
  - Quotient = sign_q ? -quo : quo.
  - Remainder = sign_r ? -rem : rem.
- DONE:
  - div_valid=1 for exactly one cycle; next edge goes to IDLE.
  - Outputs hold their values until the next load.
- Latency, launch cycle = cycle 0:
  - Normal: valid in cycle WIDTH+1 (34).
  - Divide-by-zero: valid in cycle 1.
- Overflow (-2^31 / -1, signed):
  - Handled naturally at 33 bits: quotient 33'h0_8000_0000, remainder 0.
  - Low 32 bits match RISC-V.
- Unsigned ops: bit 32 = 0, so both signs are 0 and no correction is applied.
- div_busy = (div_start | state!=IDLE) & ~div_valid & ~div_flush, combinational.
  - The pipeline stalls until the valid cycle, then advances.
- Back-to-back ops (div_start held high across two instructions): the second launches from IDLE the cycle after valid.
- div_start dropping mid-CALC: the operation still completes and valid pulses; the dispatcher ignores it.
- div_flush=1 in any state:
  - Next state IDLE, div_valid=0 next cycle.
  - Output registers hold their previous values.
  - Flush has priority over a launch in the same cycle.
- rst has priority over flush and start; reset mid-CALC aborts without a valid pulse.
- Operands are sampled only at launch; changes to div_s1/div_s2 during CALC are ignored.

Test Plan:
- DIVU: s1=33'h0_0000_0064, s2=33'h0_0000_0007, start held -> valid only in cycle 34; quotient=14, remainder=2; busy high in cycles 0..33, low in 34.
- DIV signed: s1=33'h1_FFFF_FFF9 (-7), s2=2 -> quotient=33'h1_FFFF_FFFD (-3), remainder=33'h1_FFFF_FFFF (-1). Same operands with s2=33'h1_FFFF_FFFE (-2) -> quotient=3, remainder=-1.
- Divide-by-zero: s1=5, s2=0 -> valid in cycle 1, quotient=33'h1_FFFF_FFFF, remainder=5. Signed s1=33'h1_FFFF_FFFB, s2=0 -> remainder=33'h1_FFFF_FFFB.
- Overflow: s1=33'h1_8000_0000, s2=33'h1_FFFF_FFFF -> quotient=33'h0_8000_0000, remainder=0, valid in cycle 34.
- Flush/reset: assert div_flush in cycle 10 of a DIVU op -> no valid pulse, state IDLE, busy=0 once start drops; the following op 100/7 returns 14/2. Repeat with rst in cycle 10 -> outputs 0, valid 0.
- Back-to-back: start held high, op A 100/7 then op B 33'h1_FFFF_FFF0 / 33'h0_0000_0003 -> A valid in cycle 34, B launches in cycle 35, B valid in cycle 69 with quotient -5 (33'h1_FFFF_FFFB), remainder -1.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the M-extension execute stage.
// DIV, DIVU, REM and REMU share this datapath; operand bit 32 carries the signedness.
module div_unit #(
  parameter int WIDTH = 33,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_flush,
  input  logic [WIDTH-1:0] div_s1,
  input  logic [WIDTH-1:0] div_s2,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_valid,
  output logic             div_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;

  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_s2_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_abs1    = div_s1[WIDTH-1] ? -div_s1 : div_s1;
  assign w_abs2    = div_s2[WIDTH-1] ? -div_s2 : div_s2;
  assign w_s2_zero = (div_s2 == '0);

  // The shifted partial remainder needs one extra bit; the borrow of the trial subtract decides the quotient bit.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_div};
  assign w_fits     = w_shift[WIDTH] | ~w_trial[WIDTH];
  assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  assign div_valid = (r_state == DONE);
  assign div_busy  = (div_start | (r_state != IDLE)) & ~div_valid & ~div_flush & ~rst;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (div_start && !div_flush) begin
          w_next = w_s2_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (div_flush) begin
          w_next = IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (div_start && !div_flush) begin
            r_rem    <= '0;
            r_quo    <= w_abs1;
            r_div    <= w_abs2;
            r_sign_q <= div_s1[WIDTH-1] ^ div_s2[WIDTH-1];
            r_sign_r <= div_s1[WIDTH-1];
            r_cnt    <= '0;
            if (w_s2_zero) begin
              div_quotient  <= '1;
              div_remainder <= div_s1;
            end
          end
        end
        CALC: begin
          if (!div_flush) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            // Sign correction happens on the way into the output registers.
            if (r_cnt == LAST_CNT) begin
              div_quotient  <= r_sign_q ? -w_quo_next : w_quo_next;
              div_remainder <= r_sign_r ? -w_rem_next : w_rem_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
